// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer around one full-adder cell.
// Operands stream LSB-first, one bit per clock, with a registered carry.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    input  logic             req_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CNT_W-1:0] idx;
    logic             cout_q;
    logic             ovf_q;

    logic accept;
    logic last;
    logic fa_s;
    logic fa_c;

    // Shared full-adder cell: sum and majority carry of the current bit pair.
    always_comb begin
        fa_s = sa[0] ^ sb[0] ^ c;
        fa_c = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    end

    // Bit-step bookkeeping: a request is taken only in IDLE.
    always_comb begin
        accept = (state == IDLE) && req_valid;
        last   = (idx == LAST_IDX);
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand load at accept; one serial add step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            c      <= 1'b0;
            idx    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            sa  <= req_a;
            sb  <= req_sub ? ~req_b : req_b;
            c   <= req_sub | req_cin;
            idx <= '0;
            res <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= {fa_s, res[WIDTH-1:1]};
            c   <= fa_c;
            if (last) begin
                idx    <= '0;
                cout_q <= fa_c;
                ovf_q  <= c ^ fa_c;
            end else begin
                idx <= idx + IDX_ONE;
            end
        end
    end

    // Result outputs come straight from registers, stable through DONE.
    always_comb begin
        rsp_sum  = res;
        rsp_cout = cout_q;
        rsp_ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl.
// Expected results come from integer arithmetic, checked by a monitor.
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam longint MODV = longint'(1) << W;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_cin = 1'b0;
    logic         req_sub = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic         busy;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ut;
        longint st;
        if (sub) begin
            ut     = ua - ub;
            st     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ut     = ua + ub + longint'(cin);
            st     = sa + sb + longint'(cin);
            e.cout = (ut >= MODV);
        end
        e.sum = W'(ut);
        e.ovf = (st > MAXS) || (st < MINS);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // Wait for IDLE; in random mode, throw ignored requests at a busy block.
    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 100) begin
            if (rand_rdy && $urandom_range(0, 3) == 0) begin
                req_valid = 1'b1;
                req_a     = W'($urandom);
                req_b     = W'($urandom);
                req_cin   = 1'($urandom);
                req_sub   = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            tick();
            t++;
        end
        req_valid = 1'b0;
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
        wait_ready();
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_sub   = sub;
        req_valid = 1'b1;
        tick();
        sb_q.push_back(e);
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
    endtask

    // Directed op with rsp_ready high: checks latency and busy length.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input exp_t e);
        int lat = 1;
        int busy_n = 0;
        bit got = 1'b0;
        rsp_ready = 1'b1;
        send(a, b, cin, sub, e);
        for (int i = 0; i < 40 && !got; i++) begin
            if (busy) busy_n++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency_edges", 32'(lat), 32'(W + 1));
            chk("busy_cycles", 32'(busy_n), 32'(W));
        end
        tick();
        chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
        chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
    endtask

    // Monitor: compare each delivered response against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                    chk("rsp_cout", 32'(rsp_cout), 32'(mon_e.cout));
                    chk("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        logic rs;

        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        #14;
        rst = 1'b0;
        tick();

        do_op(8'h0F, 8'h01, 1'b0, 1'b0, '{sum: 8'h10, cout: 1'b0, ovf: 1'b0});
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1});
        do_op(8'h05, 8'h07, 1'b1, 1'b1, '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0});
        do_op(8'h80, 8'h01, 1'b0, 1'b1, '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1});

        // Backpressure in DONE plus ignored requests during RUN and DONE.
        rsp_ready = 1'b0;
        send(8'h3C, 8'h21, 1'b1, 1'b0, '{sum: 8'h5E, cout: 1'b0, ovf: 1'b0});
        tick();
        req_valid = 1'b1;
        req_a     = 8'hFF;
        req_b     = 8'hFF;
        req_sub   = 1'b1;
        tick();
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin
            tick();
            t++;
        end
        chk("bp_rsp_valid_rise", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_sum", 32'(rsp_sum), 32'h5E);
            chk("bp_rsp_cout", 32'(rsp_cout), 32'd0);
            chk("bp_rsp_ovf", 32'(rsp_ovf), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_req_ready_after", 32'(req_ready), 32'd1);
        chk("bp_rsp_valid_after", 32'(rsp_valid), 32'd0);

        // Asynchronous reset at idx=3 of 0x55+0xAA drops the operation.
        send(8'h55, 8'hAA, 1'b0, 1'b0, '{sum: 8'hFF, cout: 1'b0, ovf: 1'b0});
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        void'(sb_q.pop_back());
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("mid_rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("mid_rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        repeat (2) tick();
        #2;
        rst = 1'b0;
        do_op(8'h01, 8'h01, 1'b0, 1'b0, '{sum: 8'h02, cout: 1'b0, ovf: 1'b0});

        // Random traffic with random response backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (n % 17 == 0) ra = '1;
            if (n % 23 == 0) rb = {1'b1, {(W - 1){1'b0}}};
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell. It accepts a WIDTH-bit operand pair through a valid/ready request port and streams the operands LSB-first through the cell, one bit per clock, with a registered carry. It returns the sum, carry-out and signed overflow through a valid/ready response port. It sits between a requesting datapath and the shared full-adder resource and owns all sequencing of that cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- CNT_W, $clog2(WIDTH), bit-index counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_cin  in  1  carry-in for add; ignored when req_sub=1
- req_sub  in  1  1 = A - B (B inverted, carry-in forced to 1)
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_sum  out  WIDTH  result
- rsp_cout  out  1  carry out of MSB (sub: 1 = no borrow)
- rsp_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  out  1  state is RUN

## Operation
- States:
  - IDLE: req_ready=1.
  - RUN: WIDTH bit-steps.
  - DONE: rsp_valid=1.
- IDLE -> RUN on req_valid && req_ready. At that edge:
  - capture A into shift reg sa.
  - capture (req_sub ? ~req_b : req_b) into shift reg sb.
  - carry reg c = req_sub ? 1 : req_cin.
  - bit index idx = 0; clear result shift reg.
- RUN, each edge:
  - s = sa[0]^sb[0]^c; c_next = maj(sa[0],sb[0],c).
  - shift s into result MSB, shift sa/sb right, c <= c_next, idx++.
  - At idx==WIDTH-1, record ovf = c XOR c_next and cout = c_next, then RUN -> DONE.
- DONE: rsp_sum/rsp_cout/rsp_ovf held stable. DONE -> IDLE on rsp_ready.
- req_ready = (state==IDLE). req_valid outside IDLE is ignored, not queued.
- req_* are sampled only at the accept edge; later changes have no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset (async, any state including mid-RUN) forces:
  - state IDLE; sa, sb, c, idx, result all 0.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0, req_ready=1.
- An in-flight operation aborted by reset produces no response.

## Timing
- Accept at edge k. busy=1 for cycles after edges k..k+WIDTH-1. rsp_valid=1 from the cycle after edge k+WIDTH.
- Latency from accept to rsp_valid: WIDTH+1 edges, i.e. 9 for WIDTH=8.
- rsp_valid stays high until the edge where rsp_ready=1. rsp_valid falls and req_ready rises after that edge.
- Minimum request-to-request period: WIDTH+2 cycles, with rsp_ready tied high.
- rsp_ready while rsp_valid=0 has no effect.
- No combinational path from req_valid to req_ready or from rsp_ready to rsp_valid.
- All outputs are registered or decoded from state only.

## Test plan
- WIDTH=8, A=0x0F, B=0x01, cin=0, sub=0:
  - rsp_sum=0x10, cout=0, ovf=0.
  - rsp_valid rises exactly 9 edges after accept; busy high 8 cycles.
- A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- A=0x7F, B=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Subtract A=0x05, B=0x07, sub=1, cin=1 (ignored) -> sum=0xFE, cout=0, ovf=0.
- Subtract A=0x80, B=0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure and ignored requests:
  - Hold rsp_ready=0 for 5 cycles in DONE; outputs stay unchanged and req_ready=0.
  - Pulse req_valid during RUN with different operands; result is unaffected.
  - Raise rsp_ready; next cycle req_ready=1.
- Reset mid-operation:
  - Assert rst asynchronously (mid-cycle) at idx=3 of A=0x55+B=0xAA.
  - All outputs go to reset values immediately, with no rsp_valid.
  - After release, A=0x01+B=0x01 gives sum=0x02 with normal 9-edge latency.
